// File: rtl/carfield_pkg.sv
// Carfield shared definitions: mailbox register offsets, CTRL/STATUS bit positions,
// default regbus request/response types and the threshold saturation helper.
package carfield_pkg;

  localparam logic [4:0] MboxLetterWOffs = 5'h00;
  localparam logic [4:0] MboxLetterROffs = 5'h04;
  localparam logic [4:0] MboxStatusOffs  = 5'h08;
  localparam logic [4:0] MboxThreshOffs  = 5'h0C;
  localparam logic [4:0] MboxCtrlOffs    = 5'h10;
  localparam logic [4:0] MboxErrCntOffs  = 5'h14;

  localparam int unsigned MboxCtrlIrqEnBit   = 0;
  localparam int unsigned MboxCtrlFlushBit   = 1;
  localparam int unsigned MboxStatusEmptyBit = 0;
  localparam int unsigned MboxStatusFullBit  = 1;
  localparam int unsigned MboxStatusCntLsb   = 8;

  typedef enum logic {
    MboxIdle,
    MboxResp
  } mbox_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } mbox_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } mbox_reg_rsp_t;

  // A threshold larger than the FIFO could never be reached, so clamp it to the depth.
  function automatic logic [7:0] mboxSatThresh(input logic [7:0] val, input int unsigned depth);
    if (32'(val) > depth) return 8'(depth);
    return val;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Letter storage FIFO (common_cells fifo_v3 port set): head visible the cycle after push.
// Push while full and pop while empty are ignored; flush_i empties it in one cycle.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0] FullCnt = DEPTH[ADDR_DEPTH:0];
  localparam logic [ADDR_DEPTH:0] CntOne  = {{ADDR_DEPTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_DEPTH-1:0] readPtr;
  logic [ADDR_DEPTH-1:0] writePtr;
  logic [ADDR_DEPTH:0]   statusCnt;
  logic                  doPush;
  logic                  doPop;

  assign full_o  = (statusCnt == FullCnt);
  assign empty_o = (statusCnt == '0);
  // Wraps to zero when full; consumers combine it with full_o.
  assign usage_o = statusCnt[ADDR_DEPTH-1:0];
  assign data_o  = mem[readPtr];
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      readPtr   <= '0;
      writePtr  <= '0;
      statusCnt <= '0;
    end else if (flush_i) begin
      readPtr   <= '0;
      writePtr  <= '0;
      statusCnt <= '0;
    end else begin
      if (doPush) writePtr <= writePtr + ADDR_DEPTH'(1);
      if (doPop)  readPtr  <= readPtr + ADDR_DEPTH'(1);
      if (doPush && !doPop)      statusCnt <= statusCnt + CntOne;
      else if (doPop && !doPush) statusCnt <= statusCnt - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem[writePtr] <= data_i;
  end

endmodule

// File: rtl/carfield_mbox_responder.sv
// Host mailbox regbus slave: letter FIFO plus STATUS/THRESH/CTRL/ERRCNT registers and a level IRQ.
// Each access is accepted in IDLE and answered with a one-cycle ready pulse on the following cycle.
module carfield_mbox_responder
  import carfield_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         reg_req_t = mbox_reg_req_t,
  parameter type         reg_rsp_t = mbox_reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     irq_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  mbox_state_e          state;
  mbox_state_e          stateNext;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 fifoPush;
  logic                 fifoPop;
  logic                 fifoFlush;
  logic [AddrW-1:0]     fifoUsage;
  logic [DataWidth-1:0] fifoHead;
  logic [CntW-1:0]      count;
  logic [7:0]           threshQ;
  logic [7:0]           threshD;
  logic                 irqEnQ;
  logic                 irqEnD;
  logic [DataWidth-1:0] errCntQ;
  logic [DataWidth-1:0] errCntD;
  logic                 errInc;
  logic [DataWidth-1:0] rdataQ;
  logic [DataWidth-1:0] rdataD;
  logic [DataWidth-1:0] statusWord;
  logic                 errorQ;
  logic                 errorD;
  logic                 irqQ;
  logic [4:0]           offs;
  logic                 unusedReq;

  assign offs      = reg_req_i.addr[4:0];
  // Upper address bits and the unused strobe/data bits are don't-care for this block.
  assign unusedReq = ^reg_req_i;
  // usage wraps to 0 when full, so the full flag supplies the count MSB.
  assign count     = {fifoFull, fifoUsage};
  assign irq_o     = irqQ;

  fifo_v3 #(
    .DATA_WIDTH (DataWidth),
    .DEPTH      (Depth)
  ) iLetterFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifoFlush),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .usage_o (fifoUsage),
    .data_i  (reg_req_i.wdata),
    .push_i  (fifoPush),
    .data_o  (fifoHead),
    .pop_i   (fifoPop)
  );

  always_comb begin
    statusWord                                = '0;
    statusWord[MboxStatusEmptyBit]            = fifoEmpty;
    statusWord[MboxStatusFullBit]             = fifoFull;
    statusWord[MboxStatusCntLsb +: CntW]      = count;
  end

  always_comb begin
    stateNext = state;
    fifoPush  = 1'b0;
    fifoPop   = 1'b0;
    fifoFlush = 1'b0;
    threshD   = threshQ;
    irqEnD    = irqEnQ;
    errCntD   = errCntQ;
    errInc    = 1'b0;
    rdataD    = '0;
    errorD    = 1'b0;
    case (state)
      MboxIdle: begin
        if (reg_req_i.valid) begin
          stateNext = MboxResp;
          case (offs)
            MboxLetterWOffs: begin
              if (!reg_req_i.write)  errorD = 1'b1;
              else if (!fifoFull)    fifoPush = 1'b1;
              else begin
                errorD = 1'b1;
                errInc = 1'b1;
              end
            end
            MboxLetterROffs: begin
              if (reg_req_i.write)   errorD = 1'b1;
              else if (!fifoEmpty) begin
                fifoPop = 1'b1;
                rdataD  = fifoHead;
              end else begin
                errorD = 1'b1;
                errInc = 1'b1;
              end
            end
            MboxStatusOffs: begin
              if (reg_req_i.write) errorD = 1'b1;
              else                 rdataD = statusWord;
            end
            MboxThreshOffs: begin
              if (!reg_req_i.write)        rdataD[7:0] = threshQ;
              else if (reg_req_i.wstrb[0]) threshD = mboxSatThresh(reg_req_i.wdata[7:0], Depth);
            end
            MboxCtrlOffs: begin
              if (!reg_req_i.write) rdataD[MboxCtrlIrqEnBit] = irqEnQ;
              else if (reg_req_i.wstrb[0]) begin
                irqEnD    = reg_req_i.wdata[MboxCtrlIrqEnBit];
                fifoFlush = reg_req_i.wdata[MboxCtrlFlushBit];
              end
            end
            MboxErrCntOffs: begin
              if (reg_req_i.write) errCntD = '0;
              else                 rdataD  = errCntQ;
            end
            default: errorD = 1'b1;
          endcase
        end
      end
      MboxResp: stateNext = MboxIdle;
    endcase
    if (errInc && (errCntQ != '1)) errCntD = errCntQ + DataWidth'(1);
  end

  always_comb begin
    reg_rsp_o = '0;
    if (state == MboxResp) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = rdataQ;
      reg_rsp_o.error = errorQ;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= MboxIdle;
      threshQ <= 8'd1;
      irqEnQ  <= 1'b0;
      errCntQ <= '0;
      rdataQ  <= '0;
      errorQ  <= 1'b0;
      irqQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      threshQ <= threshD;
      irqEnQ  <= irqEnD;
      errCntQ <= errCntD;
      rdataQ  <= rdataD;
      errorQ  <= errorD;
      irqQ    <= irqEnQ && (threshQ != 8'd0) && (8'(count) >= threshQ);
    end
  end

endmodule

// File: tb/tb_carfield_mbox_responder.sv
// Bench for carfield_mbox_responder: directed scenarios and randomized traffic
// checked against a queue-based model of the mailbox.
module tb_carfield_mbox_responder;
  import carfield_pkg::*;

  localparam int Depth = 4;

  logic          clk = 1'b0;
  logic          rstN;
  mbox_reg_req_t req;
  mbox_reg_rsp_t rsp;
  logic          irq;
  int            total = 0;
  int            bad = 0;

  logic [31:0] mq[$];
  logic [7:0]  mThresh;
  logic        mIrqEn;
  logic [31:0] mErrCnt;

  carfield_mbox_responder #(
    .Depth     (Depth),
    .DataWidth (32),
    .reg_req_t (mbox_reg_req_t),
    .reg_rsp_t (mbox_reg_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    mThresh = 8'd1;
    mIrqEn  = 1'b0;
    mErrCnt = 32'd0;
  endtask

  function automatic logic exp_irq();
    return mIrqEn && (mThresh != 8'd0) && (mq.size() >= int'(mThresh));
  endfunction

  task automatic model_access(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                              input logic [3:0] strb, output logic [31:0] rd, output logic er);
    logic bump;
    rd = 32'd0; er = 1'b0; bump = 1'b0;
    case (a)
      5'h00: if (!wr) er = 1'b1; else if (mq.size() < Depth) mq.push_back(wd); else begin er = 1'b1; bump = 1'b1; end
      5'h04: if (wr) er = 1'b1; else if (mq.size() > 0) rd = mq.pop_front(); else begin er = 1'b1; bump = 1'b1; end
      5'h08: if (wr) er = 1'b1; else rd = {16'h0, 8'(mq.size()), 6'h0, mq.size() == Depth, mq.size() == 0};
      5'h0C: if (!wr) rd = {24'h0, mThresh}; else if (strb[0]) mThresh = (wd[7:0] > Depth) ? 8'(Depth) : wd[7:0];
      5'h10: if (!wr) rd = {31'h0, mIrqEn}; else if (strb[0]) begin mIrqEn = wd[0]; if (wd[1]) mq.delete(); end
      5'h14: if (wr) mErrCnt = 32'd0; else rd = mErrCnt;
      default: er = 1'b1;
    endcase
    if (bump && mErrCnt != 32'hFFFF_FFFF) mErrCnt++;
  endtask

  task automatic bus(input logic wr, input logic [4:0] a, input logic [31:0] wd, input logic [3:0] strb,
                     output logic [31:0] rd, output logic er, output int lat, output logic irqR);
    @(posedge clk); #1;
    req.addr  = {27'($urandom()), a};
    req.write = wr;
    req.wdata = wd;
    req.wstrb = strb;
    req.valid = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!rsp.ready && lat < 16) begin @(negedge clk); lat++; end
    rd = rsp.rdata; er = rsp.error; irqR = irq;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic op(input logic wr, input logic [4:0] a, input logic [31:0] wd, input logic [3:0] strb,
                    output logic [31:0] rd, output logic er, output int lat, output logic irqR,
                    output logic [31:0] expRd, output logic expEr);
    bus(wr, a, wd, strb, rd, er, lat, irqR);
    model_access(wr, a, wd, strb, expRd, expEr);
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    req = '0; rstN = 1'b0; model_reset();
    repeat (3) @(posedge clk); #1;
    total++; if (rsp !== '0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", rsp); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rstN = 1'b1;
    op(0, MboxStatusOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1 || er !== 1'b0) begin bad++; $display("FAIL reset_status got=%h/%b exp=00000001/0", rd, er); end
    op(0, MboxThreshOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL reset_thresh got=%h exp=00000001", rd); end
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_errcnt got=%h exp=0", rd); end
    op(0, MboxCtrlOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    for (int i = 0; i < 4; i++) begin
      op(1, MboxLetterWOffs, 32'hA0 + i, 4'hF, rd, er, lat, ir, erd, ee);
      total++; if (er !== 1'b0 || lat != 1) begin bad++; $display("FAIL order_wr%0d err=%b lat=%0d exp err=0 lat=1", i, er, lat); end
    end
    op(0, MboxStatusOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0402) begin bad++; $display("FAIL order_status_full got=%h exp=00000402", rd); end
    for (int i = 0; i < 4; i++) begin
      op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
      total++; if (rd !== 32'(32'hA0 + i) || er !== 1'b0 || lat != 1) begin
        bad++; $display("FAIL order_rd%0d got=%h err=%b lat=%0d exp=%h err=0 lat=1", i, rd, er, lat, 32'(32'hA0 + i));
      end
    end
    @(negedge clk);
    total++; if (rsp.ready !== 1'b0) begin bad++; $display("FAIL ready_pulse got=%b exp=0", rsp.ready); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, erd, first; logic er, ee, ir; int lat;
    first = $urandom();
    op(1, MboxLetterWOffs, first, 4'hF, rd, er, lat, ir, erd, ee);
    for (int i = 1; i < 4; i++) op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    op(1, MboxLetterWOffs, 32'hDEAD, 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL overflow_err got=%b lat=%0d exp=1 lat=1", er, lat); end
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL overflow_errcnt got=%h exp=1", rd); end
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== first || er !== 1'b0) begin bad++; $display("FAIL overflow_head got=%h/%b exp=%h/0", rd, er, first); end
    for (int i = 0; i < 3; i++) begin
      op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
      total++; if (rd !== erd || er !== ee) begin bad++; $display("FAIL overflow_drain%0d got=%h/%b exp=%h/%b", i, rd, er, erd, ee); end
    end
  endtask

  task automatic test_underflow();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL underflow_rd got=%h/%b exp=0/1", rd, er); end
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd2) begin bad++; $display("FAIL underflow_errcnt got=%h exp=2", rd); end
    op(1, MboxErrCntOffs, $urandom(), 4'h0, rd, er, lat, ir, erd, ee);
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL errcnt_clear got=%h exp=0", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    op(1, MboxThreshOffs, 32'h2, 4'hF, rd, er, lat, ir, erd, ee);
    op(1, MboxCtrlOffs, 32'h1, 4'hF, rd, er, lat, ir, erd, ee);
    op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_first got=%b exp=0", irq); end
    op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (ir !== 1'b0) begin bad++; $display("FAIL irq_not_early got=%b exp=0", ir); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_second got=%b exp=1", irq); end
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_read got=%b exp=0", irq); end
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
  endtask

  task automatic test_flush();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    for (int i = 0; i < 3; i++) op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL flush_pre_irq got=%b exp=1", irq); end
    op(1, MboxCtrlOffs, 32'h2, 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (er !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL flush_irq err=%b irq=%b exp 0/0", er, irq); end
    op(0, MboxStatusOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL flush_status got=%h exp=00000001", rd); end
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL flush_errcnt got=%h exp=0", rd); end
    op(1, MboxCtrlOffs, 32'h1, 4'hF, rd, er, lat, ir, erd, ee);
    for (int i = 0; i < 2; i++) op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    op(1, MboxCtrlOffs, 32'h3, 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL flush_keep_en_irq got=%b exp=0", irq); end
    op(0, MboxCtrlOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL flush_ctrl_read got=%h exp=00000001", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    logic [4:0] addrs [6] = '{5'h04, 5'h08, 5'h00, 5'h18, 5'h1C, 5'h02};
    logic       wrs   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    op(1, MboxLetterWOffs, 32'h5A5A_0001, 4'hF, rd, er, lat, ir, erd, ee);
    for (int i = 0; i < 6; i++) begin
      op(wrs[i], addrs[i], $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
      total++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin
        bad++; $display("FAIL bad_access a=%h wr=%b got=%h/%b lat=%0d exp=0/1 lat=1", addrs[i], wrs[i], rd, er, lat);
      end
    end
    op(0, MboxStatusOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0100) begin bad++; $display("FAIL bad_access_status got=%h exp=00000100", rd); end
    op(0, MboxErrCntOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL bad_access_errcnt got=%h exp=0", rd); end
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
  endtask

  task automatic test_wstrb();
    logic [31:0] rd, erd; logic er, ee, ir; int lat;
    op(1, MboxThreshOffs, 32'hFF, 4'hF, rd, er, lat, ir, erd, ee);
    op(0, MboxThreshOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd4) begin bad++; $display("FAIL thresh_sat got=%h exp=4", rd); end
    op(1, MboxThreshOffs, 32'h3, 4'hE, rd, er, lat, ir, erd, ee);
    op(0, MboxThreshOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd4) begin bad++; $display("FAIL thresh_strb got=%h exp=4", rd); end
    op(1, MboxThreshOffs, 32'h3, 4'h1, rd, er, lat, ir, erd, ee);
    op(0, MboxThreshOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd3) begin bad++; $display("FAIL thresh_write got=%h exp=3", rd); end
    op(1, MboxCtrlOffs, 32'h0, 4'h0, rd, er, lat, ir, erd, ee);
    op(0, MboxCtrlOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL ctrl_strb got=%h exp=1", rd); end
    op(1, MboxLetterWOffs, 32'h1234_5678, 4'h0, rd, er, lat, ir, erd, ee);
    op(0, MboxLetterROffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL letter_strb got=%h/%b exp=12345678/0", rd, er); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd; logic er, ee, ir, wr; int lat, sel; logic [4:0] a; logic [3:0] strb;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 15);
      strb = 4'($urandom());
      wd = $urandom();
      wr = 1'($urandom());
      if (sel < 6)        begin wr = 1'b1; a = MboxLetterWOffs; end
      else if (sel < 10)  begin wr = 1'b0; a = MboxLetterROffs; end
      else if (sel == 10) begin wr = 1'b0; a = MboxStatusOffs; end
      else if (sel == 11) begin a = MboxThreshOffs; wd[7:0] = 8'($urandom_range(0, 6)); end
      else if (sel == 12) begin a = MboxCtrlOffs; wd[1] = ($urandom_range(0, 3) == 0); end
      else if (sel == 13) begin a = MboxErrCntOffs; wr = ($urandom_range(0, 3) == 0); end
      else                a = 5'($urandom());
      op(wr, a, wd, strb, rd, er, lat, ir, erd, ee);
      total++; if (rd !== erd || er !== ee) begin bad++; $display("FAIL rand%0d a=%h wr=%b got=%h/%b exp=%h/%b", n, a, wr, rd, er, erd, ee); end
      total++; if (lat != 1) begin bad++; $display("FAIL rand%0d_lat got=%0d exp=1", n, lat); end
      total++; if (irq !== exp_irq()) begin bad++; $display("FAIL rand%0d_irq got=%b exp=%b", n, irq, exp_irq()); end
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [31:0] rd, erd; logic er, ee, ir; int lat; logic sawReady;
    op(1, MboxCtrlOffs, 32'h3, 4'hF, rd, er, lat, ir, erd, ee);
    op(1, MboxThreshOffs, 32'h2, 4'hF, rd, er, lat, ir, erd, ee);
    for (int i = 0; i < 2; i++) op(1, MboxLetterWOffs, $urandom(), 4'hF, rd, er, lat, ir, erd, ee);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL midrst_pre_irq got=%b exp=1", irq); end
    @(posedge clk); #1;
    req.addr = {27'h0, MboxStatusOffs}; req.write = 1'b0; req.valid = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (rsp.ready !== 1'b1) begin bad++; $display("FAIL midrst_in_resp got=%b exp=1", rsp.ready); end
    #2 rstN = 1'b0;
    #1;
    total++; if (rsp !== '0 || irq !== 1'b0) begin bad++; $display("FAIL midrst_outputs rsp=%h irq=%b exp=0/0", rsp, irq); end
    req = '0;
    @(posedge clk); @(posedge clk); #1 rstN = 1'b1;
    model_reset();
    sawReady = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp.ready) sawReady = 1'b1; end
    total++; if (sawReady !== 1'b0) begin bad++; $display("FAIL midrst_stray_ready got=%b exp=0", sawReady); end
    op(0, MboxStatusOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL midrst_status got=%h exp=00000001", rd); end
    op(0, MboxThreshOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL midrst_thresh got=%h exp=00000001", rd); end
    op(0, MboxCtrlOffs, 0, 0, rd, er, lat, ir, erd, ee);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_ctrl got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_underflow();
    test_irq();
    test_flush();
    test_errors();
    test_wstrb();
    test_random();
    test_reset_mid_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
